// File: rtl/func_gen_dds.sv
// ============================================================================
// Module   : func_gen_dds
// Purpose  : DDS function generator with glitch-free config updates at the
//            phase wrap. Optional sine mode via macro FUNC_GEN_SINE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module func_gen_dds #(
  parameter int OUT_W   = 8,
  parameter int PHASE_W = 16,
  parameter int FREQ_W  = 12,
  parameter int AMP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  input  logic [2:0]        cfg_mode,
  input  logic [FREQ_W-1:0] cfg_freq,
  input  logic [OUT_W-1:0]  cfg_duty,
  input  logic [AMP_W-1:0]  cfg_amp,
  output logic              pending,
  output logic              wrap,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_final
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]        mode;
    logic [FREQ_W-1:0] freq;
    logic [OUT_W-1:0]  duty;
    logic [AMP_W-1:0]  amp;
  } cfg_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  cfg_t               act_q, act_d;
  cfg_t               shd_q, shd_d;
  logic [OUT_W-1:0]   wave_q, wave_d;
  logic [AMP_W-1:0]   amp_s1_q, amp_s1_d;
  logic               vld_s1_q, vld_s1_d;
  logic [OUT_W-1:0]   out_final_q, out_final_d;
  logic               out_valid_q, out_valid_d;

  cfg_t               cfg_in;
  logic [PHASE_W:0]   sum;
  logic               carry;
  logic [OUT_W-1:0]   p, q, wave;
  logic [OUT_W+AMP_W-1:0] prod;
  logic [OUT_W-1:0]   scaled;

  assign cfg_in = {cfg_mode, cfg_freq, cfg_duty, cfg_amp};
  assign sum    = {1'b0, acc_q} + {{(PHASE_W + 1 - FREQ_W){1'b0}}, act_q.freq};
  assign carry  = (state_q != IDLE) && en && sum[PHASE_W];

  // Control: accumulator, active/shadow config and the load state machine
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    act_d   = act_q;
    shd_d   = shd_q;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (ld) act_d = cfg_in;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          if (ld) act_d = cfg_in;
        end else begin
          acc_d = sum[PHASE_W-1:0];
          if (ld) begin
            shd_d   = cfg_in;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          act_d   = ld ? cfg_in : shd_q;
        end else begin
          acc_d = sum[PHASE_W-1:0];
          // A stalled phase (freq 0) would never wrap, so release the shadow now
          if (carry || (act_q.freq == '0)) begin
            act_d   = ld ? cfg_in : shd_q;
            state_d = RUN;
          end else if (ld) begin
            shd_d = cfg_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign p = acc_q[PHASE_W-1 -: OUT_W];
  assign q = acc_q[PHASE_W-2 -: OUT_W];

`ifdef FUNC_GEN_SINE_EN
  localparam int SINE_N   = 1 << (OUT_W - 2);
  localparam longint SINE_A   = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint SINE_MID = longint'(1) << (OUT_W - 1);

  // Bhaskara sine approximation, evaluated only at elaboration to fill the ROM
  function automatic logic [OUT_W-1:0] sine_entry(input int i);
    longint n2, dd, u, num, den;
    n2  = 2 * longint'(SINE_N);
    dd  = n2 * n2;
    u   = longint'(i) * (n2 - longint'(i));
    num = 32 * SINE_A * u;
    den = 5 * dd - 4 * u;
    return OUT_W'(SINE_MID + (num + den) / (2 * den));
  endfunction

  logic [OUT_W-1:0] sine_rom [SINE_N];
  logic [1:0]       sine_quad;
  logic [OUT_W-3:0] sine_idx;
  logic [OUT_W-1:0] sine_val;

  for (genvar gi = 0; gi < SINE_N; gi++) begin : g_sine_rom
    assign sine_rom[gi] = sine_entry(gi);
  end

  assign sine_quad = acc_q[PHASE_W-1 -: 2];
  assign sine_idx  = sine_quad[0] ? ~acc_q[PHASE_W-3 -: OUT_W-2] : acc_q[PHASE_W-3 -: OUT_W-2];
  assign sine_val  = sine_quad[1] ? ~sine_rom[sine_idx] : sine_rom[sine_idx];
`endif

  always_comb begin
    wave = '0;
    case (act_q.mode)
      3'd0: wave = (p < act_q.duty) ? '1 : '0;
      3'd1: wave = p;
      3'd2: wave = acc_q[PHASE_W-1] ? ~q : q;
      3'd3: wave = ~p;
`ifdef FUNC_GEN_SINE_EN
      3'd4: wave = sine_val;
`endif
      default: wave = '0;
    endcase
  end

  // Amplitude travels with its sample so a config swap never mixes generations
  assign prod   = {{AMP_W{1'b0}}, wave_q} * {{OUT_W{1'b0}}, amp_s1_q};
  assign scaled = (amp_s1_q == '1) ? wave_q : OUT_W'(prod >> AMP_W);

  always_comb begin
    wave_d      = '0;
    amp_s1_d    = '0;
    vld_s1_d    = 1'b0;
    out_final_d = '0;
    out_valid_d = 1'b0;
    if (state_q != IDLE) begin
      wave_d      = wave;
      amp_s1_d    = act_q.amp;
      vld_s1_d    = 1'b1;
      out_final_d = scaled;
      out_valid_d = vld_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      act_q       <= '0;
      shd_q       <= '0;
      wave_q      <= '0;
      amp_s1_q    <= '0;
      vld_s1_q    <= 1'b0;
      out_final_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      wave_q      <= wave_d;
      amp_s1_q    <= amp_s1_d;
      vld_s1_q    <= vld_s1_d;
      out_final_q <= out_final_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pending   = (state_q == PEND);
  assign wrap      = carry;
  assign out_valid = out_valid_q;
  assign out_final = out_final_q;

endmodule

`default_nettype wire

// File: tb/tb_func_gen_dds.sv
// ============================================================================
// Module   : tb_func_gen_dds
// Purpose  : Directed self-checking bench for func_gen_dds (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_func_gen_dds;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ld;
  logic [2:0]  cfg_mode;
  logic [11:0] cfg_freq;
  logic [7:0]  cfg_duty;
  logic [7:0]  cfg_amp;
  logic        pending;
  logic        wrap;
  logic        out_valid;
  logic [7:0]  out_final;

  int n_total = 0;
  int n_bad   = 0;

  func_gen_dds #(
    .OUT_W  (8),
    .PHASE_W(16),
    .FREQ_W (12),
    .AMP_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ld       (ld),
    .cfg_mode (cfg_mode),
    .cfg_freq (cfg_freq),
    .cfg_duty (cfg_duty),
    .cfg_amp  (cfg_amp),
    .pending  (pending),
    .wrap     (wrap),
    .out_valid(out_valid),
    .out_final(out_final)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] m, input logic [11:0] f,
                      input logic [7:0] d, input logic [7:0] a);
    cfg_mode = m;
    cfg_freq = f;
    cfg_duty = d;
    cfg_amp  = a;
    ld       = 1'b1;
    tick();
    ld       = 1'b0;
  endtask

  task automatic stop_run();
    en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int exp_seq [4];
    int expv;
    int j;
`ifdef FUNC_GEN_SINE_EN
    int sine_exp [4];
    sine_exp = '{32'h80, 32'hFF, 32'h7F, 32'h00};
`endif
    exp_seq = '{32'hFF, 32'h00, 32'h02, 32'h04};

    rst = 1'b0; en = 1'b0; ld = 1'b0;
    cfg_mode = '0; cfg_freq = '0; cfg_duty = '0; cfg_amp = '0;
    repeat (3) tick();
    check("rst_out",     32'(out_final), 0);
    check("rst_valid",   32'(out_valid), 0);
    check("rst_pending", 32'(pending),   0);
    check("rst_wrap",    32'(wrap),      0);
    rst = 1'b1;
    tick();

    // Sawtooth, one LSB per clock, 256-cycle period
    load(3'd1, 12'h100, 8'h00, 8'hFF);
    en = 1'b1;
    tick();
    check("saw_v0", 32'(out_valid), 0);
    tick();
    check("saw_v1", 32'(out_valid), 0);
    tick();
    check("saw_v2", 32'(out_valid), 1);
    check("saw_o2", 32'(out_final), 0);
    for (int k = 3; k <= 258; k++) begin
      tick();
      check("saw", 32'(out_final), (k - 2) & 255);
      check("saw_wrap", 32'(wrap), 32'((k % 256) == 255));
    end

    // Deferred load: two writes while pending, only the second survives
    cfg_mode = 3'd1; cfg_freq = 12'h800; cfg_duty = 8'h00; cfg_amp = 8'hFF;
    ld = 1'b1;
    tick();
    check("pend_set", 32'(pending), 1);
    cfg_freq = 12'h200;
    tick();
    ld = 1'b0;
    check("pend_rewrite", 32'(pending), 1);
    for (int k = 261; k <= 510; k++) begin
      tick();
      check("pend_wait", 32'(pending), 1);
    end
    tick();
    check("pend_wrap", 32'(wrap), 1);
    check("pend_at_wrap", 32'(pending), 1);
    tick();
    check("pend_clear", 32'(pending), 0);
    check("pend_wrap_off", 32'(wrap), 0);
    check("pend_old_fe", 32'(out_final), 32'hFE);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("newfreq_out", 32'(out_final), exp_seq[k]);
    end
    for (j = 5; j <= 128; j++) begin
      tick();
      check("newfreq_wrap", 32'(wrap), 32'(j == 127));
    end

    // Leaving RUN: valid drops one cycle after IDLE is entered
    en = 1'b0;
    tick();
    check("idle_v0", 32'(out_valid), 1);
    tick();
    check("idle_v1", 32'(out_valid), 0);
    check("idle_out", 32'(out_final), 0);
    check("idle_pend", 32'(pending), 0);

    // Square, half duty, 64-cycle period
    load(3'd0, 12'h400, 8'h80, 8'hFF);
    en = 1'b1;
    tick();
    tick();
    for (int k = 2; k <= 129; k++) begin
      tick();
      j = k - 2;
      check("square", 32'(out_final), ((j % 64) < 32) ? 255 : 0);
    end

    // Triangle at half amplitude
    stop_run();
    load(3'd2, 12'h400, 8'h00, 8'h80);
    en = 1'b1;
    tick();
    tick();
    for (int k = 2; k <= 65; k++) begin
      tick();
      j = k - 2;
      expv = (j < 32) ? (8 * j) : (255 - 8 * (j - 32));
      check("triangle", 32'(out_final), expv >> 1);
    end

    // Mode 4
    stop_run();
    load(3'd4, 12'h100, 8'h00, 8'hFF);
    en = 1'b1;
    tick();
    tick();
    for (int k = 2; k <= 194; k++) begin
      tick();
      j = k - 2;
`ifdef FUNC_GEN_SINE_EN
      if ((j % 64) == 0) check("sine", 32'(out_final), sine_exp[j / 64]);
`else
      check("mode4_off", 32'(out_final), 0);
`endif
    end

    // Asynchronous reset between edges while pending and live
    ld = 1'b1;
    tick();
    ld = 1'b0;
    check("pre_rst_pend", 32'(pending), 1);
    check("pre_rst_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out",   32'(out_final), 0);
    check("arst_valid", 32'(out_valid), 0);
    check("arst_pend",  32'(pending),   0);
    check("arst_wrap",  32'(wrap),      0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/func_gen_dds.md
Name: func_gen_dds

Overview:
- Parametrised direct-digital-synthesis function generator; next generation of the Lab 3 function generator.
- Phase accumulator drives a selectable waveform with programmable frequency, duty and amplitude.
- Config changes load through a shadow register and take effect at the phase wrap, so the output never glitches.
- Feeds the DAC/scope output stage via out_final.

Parameters:
- OUT_W, 8: output sample width.
- PHASE_W, 16: phase accumulator width; must be >= OUT_W+1.
- FREQ_W, 12: frequency tuning word width; must be <= PHASE_W.
- AMP_W, 8: amplitude scale width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; level-sensitive.
- ld  in  1  config load strobe; sampled every clk edge.
- cfg_mode  in  3  0 square, 1 sawtooth, 2 triangle, 3 ramp-down, 4 sine (SINE_EN only), others reserved.
- cfg_freq  in  FREQ_W  phase increment per clock.
- cfg_duty  in  OUT_W  square high-threshold.
- cfg_amp  in  AMP_W  amplitude scale.
- pending  out  1  shadow config is waiting for a wrap.
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- out_valid  out  1  out_final carries a live sample.
- out_final  out  OUT_W  waveform sample, unsigned.

Behaviour:
- Reset (rst=0, asynchronous): accumulator 0, active and shadow config 0, state IDLE, pending 0, wrap 0, out_valid 0, out_final 0.
- States:
  - IDLE (en=0): accumulator held at 0, output pipeline flushed to 0, out_valid 0.
  - RUN: accumulator advances each cycle.
  - PEND: as RUN, with a shadow config waiting.
- Transitions:
  - IDLE -> RUN when en=1; phase starts at 0.
  - RUN/PEND -> IDLE when en=0; accumulator cleared; any pending shadow is applied immediately.
  - RUN -> PEND when ld=1; cfg_* captured into shadow; pending=1.
  - PEND -> RUN at wrap; shadow copied to active; pending=0 the cycle after wrap.
- ld in IDLE: cfg_* written straight to active next cycle; pending stays 0.
- ld while PEND: shadow overwritten, last write wins.
- ld in the same cycle as wrap in PEND: incoming cfg_* goes straight to active; pending=0.
- Active freq=0 in RUN/PEND: phase holds and wrap never fires; a pending shadow is applied on the next cycle.
- Accumulator: acc <= acc + zero-extended freq, modulo 2^PHASE_W. wrap=1 on carry-out.
- Waveform: p = acc[PHASE_W-1 -: OUT_W].
  - Sawtooth: p.
  - Ramp-down: ~p.
  - Triangle: q = acc[PHASE_W-2 -: OUT_W]; output q when acc MSB=0, ~q when MSB=1.
  - Square: all-ones when p < duty, else 0. duty=0 gives constant 0.
  - Reserved modes: 0.
- Amplitude: out = (wave*amp) >> AMP_W, except amp = all-ones passes the wave unscaled. Product width OUT_W+AMP_W; no overflow possible.
- Latency: stage 1 registers the wave from acc; stage 2 registers the scaled sample into out_final.
  - out_final follows acc by 2 clocks.
  - out_valid rises 2 cycles after entering RUN and falls 1 cycle after entering IDLE.

Optional Feature:
- Macro: FUNC_GEN_SINE_EN.
- Defined: mode 4 produces a sine from a quarter-wave ROM of 2^(OUT_W-2) entries, indexed by acc bits below the top two.
  - Top two bits select the quadrant: mirror the index for quadrants 1 and 3, invert the value for quadrants 2 and 3.
  - Output is offset-binary centred on 2^(OUT_W-1).
  - Adds no latency: the ROM read sits inside stage 1.
- Undefined: mode 4 is reserved and outputs 0; no ROM is instantiated.

Test Plan (defaults):
- Reset mid-RUN: assert rst=0 asynchronously between edges -> all outputs 0 immediately, with no clock edge needed.
- Sawtooth: ld with mode=1, freq=0x100, amp=0xFF in IDLE, then en=1 -> out_valid high 2 cycles later; out_final counts 0,1,2..255 one step per clock; wrap every 256 cycles.
- Square, half duty: mode=0, freq=0x400, duty=0x80 -> 32 cycles 0xFF then 32 cycles 0x00; period 64 cycles.
- Triangle with scaling: mode=2, freq=0x400, amp=0x80 -> peak 0x7F, trough 0; symmetric 64-cycle period.
- Deferred load: ld with freq=0x800 mid-period during RUN -> pending=1; old 256-cycle period completes; new freq starts exactly after wrap; pending clears. A second ld while PEND -> only the second value is applied.
- Sine (FUNC_GEN_SINE_EN defined): mode=4, freq=0x100 -> out_final 0x80 at phase 0, near 0xFF at quarter period, near 0x00 at three-quarter period.
- Sine (FUNC_GEN_SINE_EN undefined): mode=4 -> out_final 0.
